// File: rtl/snake_pkg.sv
// Shared widths, direction and state encodings for the snake movement logic.
package snake_pkg;

   localparam int X_W       = 7;
   localparam int Y_W       = 6;
   localparam int TAIL_LEN  = 15;
   localparam int MAX_SCORE = 15;
   localparam int SCORE_W   = 4;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   // Opposite pairs differ only in bit 0 (up/down, left/right).
   function automatic logic [1:0] dir_reverse(input logic [1:0] d);
      return {d[1], ~d[0]};
   endfunction

endpackage

// File: rtl/snake_tail_shift.sv
// Tail segment history: on each shift, segment 0 takes the head and every
// other segment takes its predecessor; the oldest segment falls off.
module snake_tail_shift
   import snake_pkg::*;
(
   input  logic                      clk,
   input  logic                      i_rst_n,
   input  logic                      i_shift,
   input  logic [X_W-1:0]            i_head_x,
   input  logic [Y_W-1:0]            i_head_y,
   output logic [TAIL_LEN*X_W-1:0]   o_tail_x,
   output logic [TAIL_LEN*Y_W-1:0]   o_tail_y
);

   logic [TAIL_LEN*X_W-1:0] r_tail_x;
   logic [TAIL_LEN*Y_W-1:0] r_tail_y;

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_tail_x <= '0;
         r_tail_y <= '0;
      end else if (i_shift) begin
         r_tail_x <= {r_tail_x[(TAIL_LEN-1)*X_W-1:0], i_head_x};
         r_tail_y <= {r_tail_y[(TAIL_LEN-1)*Y_W-1:0], i_head_y};
      end
   end

   assign o_tail_x = r_tail_x;
   assign o_tail_y = r_tail_y;

endmodule

// File: rtl/snake_mover.sv
// Snake head/direction/score controller with IDLE/RUN/HALT sequencing.
// Valid/ready note: dir_valid qualifies dir_req for one cycle; there is no back-pressure.
module snake_mover
   import snake_pkg::*;
#(
   parameter int START_X   = 40,
   parameter int START_Y   = 30,
   parameter int MAX_SCORE = snake_pkg::MAX_SCORE
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      move_tick,
   input  logic                      dir_valid,
   input  logic [1:0]                dir_req,
   input  logic [X_W-1:0]            food_x,
   input  logic [Y_W-1:0]            food_y,
   input  logic                      game_over,
   input  logic                      victory,
   output logic [X_W-1:0]            head_x,
   output logic [Y_W-1:0]            head_y,
   output logic [TAIL_LEN*X_W-1:0]   tail_x,
   output logic [TAIL_LEN*Y_W-1:0]   tail_y,
   output logic [SCORE_W-1:0]        score,
   output logic [1:0]                dir,
   output logic                      food_eaten,
   output logic                      running,
   output logic [1:0]                dbg_state
);

   localparam logic [X_W-1:0]     START_X_V = X_W'(START_X);
   localparam logic [Y_W-1:0]     START_Y_V = Y_W'(START_Y);
   localparam logic [SCORE_W-1:0] MAX_V     = SCORE_W'(MAX_SCORE);

   state_t               r_state;
   state_t               w_state_next;
   logic [X_W-1:0]       r_head_x;
   logic [Y_W-1:0]       r_head_y;
   logic [1:0]           r_dir;
   logic [1:0]           r_pending_dir;
   logic [SCORE_W-1:0]   r_score;
   logic                 r_food_eaten;

   logic                 w_move;
   logic                 w_dir_accept;
   logic [1:0]           w_eff_dir;
   logic [X_W-1:0]       w_next_x;
   logic [Y_W-1:0]       w_next_y;
   logic                 w_food_hit;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // game_over and victory both end the run; either one also blocks the move.
   always_comb begin
      w_state_next = r_state;
      w_move       = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_state_next = S_RUN;
         S_RUN: begin
            if (game_over || victory) w_state_next = S_HALT;
            else if (move_tick)       w_move       = 1'b1;
         end
         default: w_state_next = r_state;
      endcase
   end

   // Reverse requests are judged against the committed direction, not the pending one.
   assign w_dir_accept = (r_state == S_RUN) && dir_valid &&
                         (dir_req != dir_reverse(r_dir));
   assign w_eff_dir    = w_dir_accept ? dir_req : r_pending_dir;

   always_comb begin
      w_next_x = r_head_x;
      w_next_y = r_head_y;
      case (w_eff_dir)
         DIR_UP:    w_next_y = r_head_y - 1'b1;
         DIR_DOWN:  w_next_y = r_head_y + 1'b1;
         DIR_LEFT:  w_next_x = r_head_x - 1'b1;
         DIR_RIGHT: w_next_x = r_head_x + 1'b1;
         default:   w_next_x = r_head_x;
      endcase
   end

   assign w_food_hit = (w_next_x == food_x) && (w_next_y == food_y);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_head_x      <= START_X_V;
         r_head_y      <= START_Y_V;
         r_dir         <= DIR_RIGHT;
         r_pending_dir <= DIR_RIGHT;
         r_score       <= '0;
         r_food_eaten  <= 1'b0;
      end else begin
         r_food_eaten <= 1'b0;
         if (w_dir_accept) r_pending_dir <= dir_req;
         if (w_move) begin
            r_dir         <= w_eff_dir;
            r_pending_dir <= w_eff_dir;
            r_head_x      <= w_next_x;
            r_head_y      <= w_next_y;
            if (w_food_hit && (r_score < MAX_V)) begin
               r_score      <= r_score + 1'b1;
               r_food_eaten <= 1'b1;
            end
         end
      end
   end

   snake_tail_shift u_tail (
      .clk      (clk),
      .i_rst_n  (reset),
      .i_shift  (w_move),
      .i_head_x (r_head_x),
      .i_head_y (r_head_y),
      .o_tail_x (tail_x),
      .o_tail_y (tail_y)
   );

   assign head_x     = r_head_x;
   assign head_y     = r_head_y;
   assign score      = r_score;
   assign dir        = r_dir;
   assign food_eaten = r_food_eaten;
   assign running    = (r_state == S_RUN);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_snake_mover.sv
// Directed bench for snake_mover with hand-computed expected values.
module tb_snake_mover;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          move_tick;
   logic          dir_valid;
   logic [1:0]    dir_req;
   logic [6:0]    food_x;
   logic [5:0]    food_y;
   logic          game_over;
   logic          victory;
   logic [6:0]    head_x;
   logic [5:0]    head_y;
   logic [104:0]  tail_x;
   logic [89:0]   tail_y;
   logic [3:0]    score;
   logic [1:0]    dir;
   logic          food_eaten;
   logic          running;
   logic [1:0]    dbg_state;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HALT = 2'd2;

   snake_mover dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .move_tick  (move_tick),
      .dir_valid  (dir_valid),
      .dir_req    (dir_req),
      .food_x     (food_x),
      .food_y     (food_y),
      .game_over  (game_over),
      .victory    (victory),
      .head_x     (head_x),
      .head_y     (head_y),
      .tail_x     (tail_x),
      .tail_y     (tail_y),
      .score      (score),
      .dir        (dir),
      .food_eaten (food_eaten),
      .running    (running),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_x(input int k);
      return tail_x[7*k +: 7];
   endfunction

   function automatic logic [5:0] seg_y(input int k);
      return tail_y[6*k +: 6];
   endfunction

   // Inputs change 1 time unit after the rising edge; checks happen there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic tick_edge();
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
   endtask

   task automatic tick();
      tick_edge();
      step();
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_head_x"}, 128'(head_x), 128'd40);
      check_val({tag, "_head_y"}, 128'(head_y), 128'd30);
      check_val({tag, "_tail_x"}, 128'(tail_x), 128'd0);
      check_val({tag, "_tail_y"}, 128'(tail_y), 128'd0);
      check_val({tag, "_score"},  128'(score), 128'd0);
      check_val({tag, "_dir"},    128'(dir), 128'd3);
      check_val({tag, "_food"},   128'(food_eaten), 128'd0);
      check_val({tag, "_run"},    128'(running), 128'd0);
      check_val({tag, "_state"},  128'(dbg_state), 128'(ST_IDLE));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; move_tick = 1'b0; dir_valid = 1'b0;
      dir_req = 2'd0; food_x = 7'd0; food_y = 6'd0; game_over = 1'b0; victory = 1'b0;
      step();
      step();
      reset = 1'b1;
      check_reset_state("rst");

      // First move to the right.
      pulse_start();
      check_val("start_run", 128'(running), 128'd1);
      tick();
      check_val("t1_hx", 128'(head_x), 128'd41);
      check_val("t1_hy", 128'(head_y), 128'd30);
      check_val("t1_s0x", 128'(seg_x(0)), 128'd40);
      check_val("t1_s0y", 128'(seg_y(0)), 128'd30);
      check_val("t1_score", 128'(score), 128'd0);

      // Reverse request dropped.
      dir_valid = 1'b1; dir_req = 2'd2;
      step();
      dir_valid = 1'b0;
      tick();
      check_val("rev_hx", 128'(head_x), 128'd42);
      check_val("rev_dir", 128'(dir), 128'd3);

      // Two accepted requests before a tick: the later one (down) wins.
      dir_valid = 1'b1; dir_req = 2'd0;
      step();
      dir_req = 2'd1;
      step();
      dir_valid = 1'b0;
      tick();
      check_val("last_hx", 128'(head_x), 128'd42);
      check_val("last_hy", 128'(head_y), 128'd31);
      check_val("last_dir", 128'(dir), 128'd1);

      // Request in the same cycle as the tick takes effect immediately.
      dir_valid = 1'b1; dir_req = 2'd2;
      tick_edge();
      dir_valid = 1'b0;
      step();
      check_val("same_hx", 128'(head_x), 128'd41);
      check_val("same_hy", 128'(head_y), 128'd31);
      check_val("same_dir", 128'(dir), 128'd2);
      check_val("same_s0x", 128'(seg_x(0)), 128'd42);
      check_val("same_s0y", 128'(seg_y(0)), 128'd31);
      check_val("same_s1y", 128'(seg_y(1)), 128'd30);
      check_val("same_s2x", 128'(seg_x(2)), 128'd41);
      check_val("same_s3x", 128'(seg_x(3)), 128'd40);

      // Upward wrap of the 6-bit y field.
      do_reset();
      pulse_start();
      dir_valid = 1'b1; dir_req = 2'd0;
      step();
      dir_valid = 1'b0;
      for (int i = 0; i < 31; i++) tick();
      check_val("wrap_hy", 128'(head_y), 128'd63);
      check_val("wrap_hx", 128'(head_x), 128'd40);
      check_val("wrap_s0y", 128'(seg_y(0)), 128'd0);

      // Food at (42,30), eaten on the second tick.
      do_reset();
      food_x = 7'd42; food_y = 6'd30;
      pulse_start();
      tick_edge();
      check_val("f1_eaten", 128'(food_eaten), 128'd0);
      step();
      tick_edge();
      check_val("f2_eaten", 128'(food_eaten), 128'd1);
      check_val("f2_score", 128'(score), 128'd1);
      check_val("f2_s0x", 128'(seg_x(0)), 128'd41);
      check_val("f2_s0y", 128'(seg_y(0)), 128'd30);
      step();
      check_val("f3_eaten", 128'(food_eaten), 128'd0);
      check_val("f3_score", 128'(score), 128'd1);

      // game_over on a tick: no move, HALT, later ticks and start ignored.
      game_over = 1'b1;
      tick_edge();
      game_over = 1'b0;
      check_val("go_hx", 128'(head_x), 128'd42);
      check_val("go_state", 128'(dbg_state), 128'(ST_HALT));
      check_val("go_run", 128'(running), 128'd0);
      step();
      tick();
      pulse_start();
      tick();
      check_val("halt_hx", 128'(head_x), 128'd42);
      check_val("halt_state", 128'(dbg_state), 128'(ST_HALT));

      // Score up to 15, then saturation, then victory.
      do_reset();
      food_y = 6'd30;
      pulse_start();
      for (int k = 0; k < 14; k++) begin
         food_x = 7'(41 + k);
         tick();
      end
      check_val("s14_score", 128'(score), 128'd14);
      food_x = 7'd55;
      tick_edge();
      check_val("s15_score", 128'(score), 128'd15);
      check_val("s15_eaten", 128'(food_eaten), 128'd1);
      step();
      food_x = 7'd56;
      tick_edge();
      check_val("sat_score", 128'(score), 128'd15);
      check_val("sat_eaten", 128'(food_eaten), 128'd0);
      check_val("sat_hx", 128'(head_x), 128'd56);
      step();
      victory = 1'b1;
      food_x = 7'd57;
      tick_edge();
      victory = 1'b0;
      check_val("vic_hx", 128'(head_x), 128'd56);
      check_val("vic_state", 128'(dbg_state), 128'(ST_HALT));
      step();
      tick();
      check_val("vic_score", 128'(score), 128'd15);

      // Reset during a tick that would hit food.
      do_reset();
      pulse_start();
      tick();
      food_x = 7'd42; food_y = 6'd30;
      reset = 1'b0;
      tick_edge();
      reset = 1'b1;
      check_reset_state("midrst");
      step();
      check_val("midrst_food2", 128'(food_eaten), 128'd0);
      check_val("midrst_score2", 128'(score), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
